dec_entry_2c: RTL and testbench

//   Inverse of the 2's-complement display path. Accepts a signed decimal

---
 rtl/show_2c_pkg.sv | 23 ++
 rtl/bcd_mac10.sv | 13 +
 rtl/dec_entry_2c.sv | 146 ++++++++++++++
 tb/tb_dec_entry_2c.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/show_2c_pkg.sv
// Shared types and helpers for the signed decimal entry path.
// Sized for the default three-digit, 8-bit configuration.
package show_2c_pkg;

  localparam int NDIG_DEF = 3;
  localparam int W_DEF    = 8;
  localparam int ACC_W    = $clog2(10**NDIG_DEF);
  localparam int BCD_MAX  = 9;

  typedef logic [3:0]       bcd_t;
  typedef logic [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    CHECK
  } state_e;

  function automatic acc_t mul10_add(acc_t acc, bcd_t d);
    return (acc << 3) + (acc << 1) + acc_t'(d);
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational decimal multiply-accumulate: acc*10 + digit.
// One step of the serial BCD to binary conversion.
module bcd_mac10
  import show_2c_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       dig_i,
  output logic [ACC_W-1:0] acc_o
);

  assign acc_o = mul10_add(acc_i, dig_i);

endmodule

// File: rtl/dec_entry_2c.sv
// Keyed signed decimal entry with serial conversion to two's complement.
// Digits echo as BCD; enter converts MS digit first, one per cycle.
module dec_entry_2c
  import show_2c_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int W    = W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      digit_in,
  input  logic            digit_stb,
  input  logic            neg_stb,
  input  logic            enter_stb,
  input  logic            clr_stb,
  output logic [4*NDIG-1:0] entry_bcd,
  output logic            entry_sign,
  output logic            busy,
  output logic [W-1:0]    Dout,
  output logic            valid,
  output logic            err
);

  localparam int EW = 4*NDIG;
  localparam int CW = $clog2(NDIG+1);
  localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam acc_t LIM_POS = acc_t'(2**(W-1)-1);
  localparam acc_t LIM_NEG = acc_t'(2**(W-1));

  state_e          state_q, state_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   step_q, step_d;
  logic            sign_q, sign_d;
  acc_t            acc_q, acc_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  bcd_t            cur_dig;
  acc_t            mac_acc;
  logic            last_step;
  logic            over;
  logic            dig_ok;

  // MS digit first; unkeyed high positions are zero
  assign cur_dig   = bcd_t'(entry_q >> (4*(NDIG-1-int'(step_q))));
  assign last_step = (step_q == SW'(NDIG-1));
  assign over      = mac_acc > (sign_q ? LIM_NEG : LIM_POS);
  assign dig_ok    = (digit_in <= 4'(BCD_MAX)) && (cnt_q != CW'(NDIG));

  bcd_mac10 u_mac (
    .acc_i (acc_q),
    .dig_i (cur_dig),
    .acc_o (mac_acc)
  );

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = err_q;
    busy_d  = busy_q;
    unique case (state_q)
      CONV: begin
        acc_d  = mac_acc;
        step_d = step_q + 1'b1;
        if (last_step) begin
          state_d = CHECK;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          entry_d = '0;
          cnt_d   = '0;
          sign_d  = 1'b0;
          if (over) begin
            err_d = 1'b1;
          end else begin
            dout_d = sign_q ? -mac_acc[W-1:0] : mac_acc[W-1:0];
            err_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (clr_stb) begin
          entry_d = '0;
          cnt_d   = '0;
          sign_d  = 1'b0;
          err_d   = 1'b0;
        end else if (enter_stb) begin
          acc_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end else if (digit_stb) begin
          if (dig_ok) begin
            entry_d = {entry_q[EW-5:0], digit_in};
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (neg_stb) begin
          sign_d = ~sign_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign entry_bcd  = entry_q;
  assign entry_sign = sign_q;
  assign busy       = busy_q;
  assign Dout       = dout_q;
  assign valid      = valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dec_entry_2c.sv
// Bench for dec_entry_2c: directed cases plus random strobes
// against a digit-queue reference model.
module tb_dec_entry_2c;

  localparam int NDIG = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_stb;
  logic        neg_stb;
  logic        enter_stb;
  logic        clr_stb;
  logic [11:0] entry_bcd;
  logic        entry_sign;
  logic        busy;
  logic [7:0]  Dout;
  logic        valid;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  int q[$];
  bit m_sign, m_err, m_valid, m_vsign;
  int m_dout, m_conv, m_val;

  dec_entry_2c u_dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .digit_stb  (digit_stb),
    .neg_stb    (neg_stb),
    .enter_stb  (enter_stb),
    .clr_stb    (clr_stb),
    .entry_bcd  (entry_bcd),
    .entry_sign (entry_sign),
    .busy       (busy),
    .Dout       (Dout),
    .valid      (valid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int q_value();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic int q_bcd();
    int e = 0;
    foreach (q[i]) e = e * 16 + q[i];
    return e;
  endfunction

  task automatic model_edge(bit r, bit ds, int din, bit ns, bit es, bit cs);
    int lim;
    m_valid = 1'b0;
    if (r) begin
      q.delete();
      m_sign = 0; m_err = 0; m_dout = 0; m_conv = 0;
    end else if (m_conv > 0) begin
      m_conv--;
      if (m_conv == 0) begin
        m_valid = 1'b1;
        lim = m_vsign ? 128 : 127;
        if (m_val > lim) m_err = 1'b1;
        else begin
          m_dout = m_vsign ? (256 - m_val) % 256 : m_val;
          m_err = 1'b0;
        end
        q.delete();
        m_sign = 1'b0;
      end
    end else if (cs) begin
      q.delete();
      m_sign = 0; m_err = 0;
    end else if (es) begin
      m_val = q_value();
      m_vsign = m_sign;
      m_conv = NDIG;
    end else if (ds) begin
      if (din <= 9 && q.size() < NDIG) q.push_back(din);
    end else if (ns) begin
      m_sign = !m_sign;
    end
  endtask

  task automatic compare_all();
    chk("entry_bcd", 32'(entry_bcd), 32'(q_bcd()));
    chk("entry_sign", 32'(entry_sign), 32'(m_sign));
    chk("busy", 32'(busy), 32'(m_conv > 0));
    chk("Dout", 32'(Dout), 32'(m_dout));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic tick(bit r, bit ds, int din, bit ns, bit es, bit cs);
    @(negedge clk);
    rst = r; digit_stb = ds; digit_in = 4'(din);
    neg_stb = ns; enter_stb = es; clr_stb = cs;
    @(posedge clk);
    model_edge(r, ds, din, ns, es, cs);
    #1;
    rst = 0; digit_stb = 0; digit_in = 0;
    neg_stb = 0; enter_stb = 0; clr_stb = 0;
    compare_all();
  endtask

  task automatic key(int d);    tick(0, 1, d, 0, 0, 0); endtask
  task automatic neg();         tick(0, 0, 0, 1, 0, 0); endtask
  task automatic ent();         tick(0, 0, 0, 0, 1, 0); endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; digit_in = 0; digit_stb = 0;
    neg_stb = 0; enter_stb = 0; clr_stb = 0;
    m_sign = 0; m_err = 0; m_valid = 0; m_vsign = 0;
    m_dout = 0; m_conv = 0; m_val = 0;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    idle(1);

    // case 1
    key(5); key(8); ent();
    chk("t1_busy1", 32'(busy), 1);
    idle(2);
    chk("t1_busy3", 32'(busy), 1);
    idle(1);
    chk("t1_valid", 32'(valid), 1);
    chk("t1_busy_off", 32'(busy), 0);
    chk("t1_dout", 32'(Dout), 32'h3a);
    idle(1);

    // case 2
    neg(); key(7); key(9); ent(); idle(3);
    chk("t2_dout", 32'(Dout), 32'hb1);
    chk("t2_entry_clr", 32'(entry_bcd), 0);
    chk("t2_sign_clr", 32'(entry_sign), 0);
    idle(1);

    // case 3
    neg(); key(9); key(8); ent(); idle(3);
    chk("t3_dout_m98", 32'(Dout), 32'h9e);
    neg(); key(1); key(2); key(8); ent(); idle(3);
    chk("t3_dout_m128", 32'(Dout), 32'h80);
    chk("t3_err0", 32'(err), 0);
    key(1); key(2); key(8); ent(); idle(3);
    chk("t3_err1", 32'(err), 1);
    chk("t3_valid", 32'(valid), 1);
    chk("t3_dout_held", 32'(Dout), 32'h80);
    idle(1);

    // case 4
    key(1); key(2); key(3); key(4);
    chk("t4_entry", 32'(entry_bcd), 32'h123);
    clr_and_key();
    key(6); key(4'hc);
    chk("t4_bad_digit", 32'(entry_bcd), 32'h6);
    tick(0, 1, 5, 0, 0, 1);
    chk("t4_clr_entry", 32'(entry_bcd), 0);
    chk("t4_clr_err", 32'(err), 0);

    // case 5
    key(4);
    tick(0, 1, 7, 0, 1, 0);
    tick(0, 1, 3, 1, 0, 0);
    tick(0, 0, 0, 0, 1, 1);
    idle(1);
    chk("t5_dout4", 32'(Dout), 32'h04);
    chk("t5_entry_empty", 32'(entry_bcd), 0);
    idle(1);
    ent(); idle(3);
    chk("t5_dout0", 32'(Dout), 0);
    chk("t5_valid0", 32'(valid), 1);
    idle(1);

    // case 6
    key(5); ent(); idle(1);
    tick(1, 0, 0, 0, 0, 0);
    chk("t6_dout", 32'(Dout), 0);
    chk("t6_busy", 32'(busy), 0);
    idle(4);

    // random
    for (int i = 0; i < 4000; i++) begin
      int d;
      d = ($urandom % 4 == 0) ? int'($urandom_range(0, 15))
                              : int'($urandom_range(0, 9));
      tick(($urandom % 250) == 0, ($urandom % 100) < 40, d,
           ($urandom % 100) < 10, ($urandom % 100) < 12,
           ($urandom % 100) < 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic clr_and_key();
    tick(0, 0, 0, 0, 0, 1);
  endtask

endmodule
